timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 5, SHALL set the width of the period register and of the internal counter.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 cfg_valid  input  1  SHALL mean a configuration is offered.
REQ-005 cfg_ready  output  1  SHALL mean a configuration can be accepted.
REQ-006 cfg_period  input  DATA_WIDTH  SHALL carry the period P in cycles.
REQ-007 cfg_periodic  input  1  SHALL select the mode: 1 = periodic, 0 = one-shot.
REQ-008 start  input  1  SHALL be the run request, sampled each edge.
REQ-009 stop  input  1  SHALL be the abort request, sampled each edge.
REQ-010 irq_ack  input  1  SHALL acknowledge and clear irq.
REQ-011 count  output  DATA_WIDTH  SHALL be the current counter value.
REQ-012 tick  output  1  SHALL be a one-cycle pulse at period expiry.
REQ-013 irq  output  1  SHALL be a level set by tick and held until acknowledged.
REQ-014 ovf  output  1  SHALL be a sticky flag indicating a tick was lost while irq was pending.
REQ-015 busy  output  1  SHALL be high exactly when state is RUN.
REQ-016 err  output  1  SHALL be a one-cycle pulse on a rejected configuration or start.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 cfg_ready SHALL be 1 in IDLE and DONE and 0 in RUN.
REQ-019 A config handshake (cfg_valid & cfg_ready at an edge) SHALL capture P and mode and clear ovf.
REQ-020 A handshake with cfg_period=0 SHALL leave the stored config unchanged and pulse err in the next cycle.
REQ-021 start in IDLE or DONE with stored P≠0 SHALL move to RUN at that edge, with count=0 and busy=1 in the next cycle.
REQ-022 start with stored P=0 and no simultaneous valid handshake SHALL pulse err and leave the state unchanged.
REQ-023 start coincident with a valid handshake (P≠0) SHALL run using the newly captured config.
REQ-024 start in RUN SHALL be ignored.
REQ-025 In RUN, count SHALL increment by 1 per cycle; at the edge where count==P-1, count SHALL become 0 and tick SHALL be 1 in the following cycle.
REQ-026 The first tick SHALL occur P cycles after the start edge; in periodic mode, subsequent ticks SHALL occur every P cycles with no gap.
REQ-027 P=1 in periodic mode SHALL produce tick=1 every cycle.
REQ-028 count SHALL never exceed P-1 and SHALL never wrap past 2^DATA_WIDTH-1 (maximum P = 2^DATA_WIDTH-1).
REQ-029 In one-shot mode, the expiry edge SHALL move the FSM to DONE with count=0 and busy=0 alongside the tick.
REQ-030 stop in RUN SHALL move to IDLE at that edge with count=0.
REQ-031 stop SHALL suppress a coincident expiry, so no tick is issued.
REQ-032 stop in IDLE or DONE SHALL move to IDLE with no other effect.
REQ-033 stop and start in the same cycle: stop SHALL win.
REQ-034 irq SHALL set in the same cycle tick is 1.
REQ-035 irq SHALL clear on the edge where irq_ack=1 and no new tick is being generated.
REQ-036 irq_ack coincident with a new tick SHALL leave irq=1 and ovf unchanged.
REQ-037 A tick while irq=1 and irq_ack=0 SHALL set ovf=1; ovf SHALL stay set until reset or the next config handshake.

Reset
REQ-038 While reset=1, regardless of clk: state=IDLE, count=0, tick=0, irq=0, ovf=0, busy=0, err=0, cfg_ready=1, stored P=0, stored mode=0.
REQ-039 Reset asserted mid-RUN SHALL abort immediately with no tick; operation SHALL resume on the first edge after deassertion.

Verification
REQ-040 The bench SHALL cover: DATA_WIDTH=5, cfg P=4 periodic, start -> tick every 4 cycles; count sequence 0,1,2,3,0; irq set on first tick.
REQ-041 The bench SHALL cover: P=3 one-shot, start -> single tick 3 cycles after start; state DONE; busy=0; cfg_ready=1; count=0.
REQ-042 The bench SHALL cover: cfg P=0, and start after reset -> err pulses once for each, busy stays 0.
REQ-043 The bench SHALL cover: P=2 periodic, irq_ack never asserted -> second tick sets ovf=1; a new cfg handshake clears ovf.
REQ-044 The bench SHALL cover: stop asserted on the expiry cycle with P=5 -> no tick; IDLE; count=0.
REQ-045 The bench SHALL cover: reset pulse mid-RUN between clock edges (P=31) -> all outputs return to reset values immediately and start works again afterwards.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_ctrl_if
//   Signal bundle between a timer controller and the block that drives it.
//
//   Handshake: a configuration transfers on any rising clk edge where
//   cfg_valid and cfg_ready are both 1. cfg_period and cfg_periodic must be
//   stable whenever cfg_valid is 1. cfg_ready does not depend on cfg_valid.
//
//   master : drives configuration, start/stop requests and irq_ack
//   slave  : the timer; drives count, tick, irq, ovf, busy, err, cfg_ready
//            and the debug FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
// ---------------------------------------------------------------------------
interface timer_ctrl_if #(
    parameter int DATA_WIDTH = 5
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [DATA_WIDTH-1:0] cfg_period;
    logic                  cfg_periodic;
    logic                  start;
    logic                  stop;
    logic                  irq_ack;
    logic [DATA_WIDTH-1:0] count;
    logic                  tick;
    logic                  irq;
    logic                  ovf;
    logic                  busy;
    logic                  err;
    logic [1:0]            state;

    modport master (
        output cfg_valid, cfg_period, cfg_periodic, start, stop, irq_ack,
        input  cfg_ready, count, tick, irq, ovf, busy, err, state
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_periodic, start, stop, irq_ack,
        output cfg_ready, count, tick, irq, ovf, busy, err, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//   Programmable period timer with one-shot and periodic modes, a sticky
//   interrupt with acknowledge, and an overflow flag for ticks lost while
//   the interrupt is still pending.
//
//   Ports
//     clk    : single clock, all state updates on its rising edge
//     reset  : asynchronous, active-high reset
//     bus    : timer_ctrl_if.slave
//                cfg_valid/cfg_ready/cfg_period/cfg_periodic : configuration
//                start, stop                                 : run control
//                irq_ack                                     : clears irq
//                count, tick, irq, ovf, busy, err            : status
//                state                                       : debug FSM state
// ---------------------------------------------------------------------------
module timer_ctrl #(
    parameter int DATA_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] period_q;
    logic                  periodic_q;
    logic                  tick_q;
    logic                  irq_q;
    logic                  ovf_q;
    logic                  busy_q;
    logic                  ready_q;
    logic                  err_q;

    logic                  hs;
    logic                  cfg_ok;
    logic                  cfg_bad;
    logic [DATA_WIDTH-1:0] run_period;
    logic                  expire;
    logic                  tick_gen;
    logic                  start_bad;

    always_comb begin
        hs         = bus.cfg_valid & ready_q;
        cfg_ok     = hs & (bus.cfg_period != '0);
        cfg_bad    = hs & (bus.cfg_period == '0);
        // A start coinciding with an accepted config runs with the new period.
        run_period = cfg_ok ? bus.cfg_period : period_q;
        expire     = (state_q == RUN) && (count_q == period_q - DATA_WIDTH'(1));
        // stop takes priority over a coincident expiry.
        tick_gen   = expire & ~bus.stop;
        // A rejected config already raises err, so only flag a bad start
        // when no handshake happens on the same edge.
        start_bad  = bus.start & ~bus.stop & (state_q != RUN) &
                     (run_period == '0) & ~hs;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            tick_q <= tick_gen;
            err_q  <= cfg_bad | start_bad;

            if (cfg_ok) begin
                period_q   <= bus.cfg_period;
                periodic_q <= bus.cfg_periodic;
            end

            if (bus.stop) begin
                state_q <= IDLE;
                count_q <= '0;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (bus.start && run_period != '0) begin
                            state_q <= RUN;
                            count_q <= '0;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (expire) begin
                            count_q <= '0;
                            if (!periodic_q) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            count_q <= count_q + DATA_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end

            // irq/ovf: a new tick wins over an acknowledge on the same edge.
            // cfg_ok and tick_gen are mutually exclusive (config only outside RUN).
            if (cfg_ok) begin
                ovf_q <= 1'b0;
            end
            if (tick_gen) begin
                irq_q <= 1'b1;
                if (irq_q && !bus.irq_ack) begin
                    ovf_q <= 1'b1;
                end
            end else if (bus.irq_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign bus.state     = state_q;
    assign bus.count     = count_q;
    assign bus.tick      = tick_q;
    assign bus.irq       = irq_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_ready = ready_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed bench for timer_ctrl (DATA_WIDTH = 5). Each step pushes the
//   expected output vector {state, cfg_ready, busy, tick, irq, ovf, err,
//   count} into exp_q and pops it once the DUT has produced that cycle.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int DW = 5;
    localparam int W  = 2 + 6 + DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic clk;
    logic reset;

    timer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    timer_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] pk(logic [1:0] st, logic rdy, logic bsy,
                                        logic tk, logic iq, logic ov, logic er,
                                        logic [DW-1:0] cn);
        return {st, rdy, bsy, tk, iq, ov, er, cn};
    endfunction

    task automatic push_exp(logic [1:0] st, logic rdy, logic bsy, logic tk,
                            logic iq, logic ov, logic er, logic [DW-1:0] cn);
        exp_q.push_back(pk(st, rdy, bsy, tk, iq, ov, er, cn));
    endtask

    task automatic chk_now(string tag);
        logic [W-1:0] obs;
        logic [W-1:0] e;
        obs = {bus.state, bus.cfg_ready, bus.busy, bus.tick, bus.irq,
               bus.ovf, bus.err, bus.count};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s observed=%h expected=queue_entry", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // one clock edge, then sample 1 time unit later
    task automatic cyc(string tag);
        @(posedge clk);
        #1;
        chk_now(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset            = 1'b1;
        bus.cfg_valid    = 1'b0;
        bus.cfg_period   = '0;
        bus.cfg_periodic = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.irq_ack      = 1'b0;

        repeat (2) begin
            @(posedge clk);
            #1;
        end
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); chk_now("reset_vals");
        reset = 1'b0;

        // zero-period config and start with nothing stored
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd0; bus.cfg_periodic = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 1, 0); cyc("cfg0_err");
        bus.cfg_valid = 1'b0;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("cfg0_err_once");
        bus.start = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 1, 0); cyc("start_p0_err");
        bus.start = 1'b0;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("start_p0_err_once");

        // P=4 periodic
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd4; bus.cfg_periodic = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("cfg4");
        bus.cfg_valid = 1'b0; bus.start = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 0); cyc("p4_c0");
        bus.start = 1'b0;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 1); cyc("p4_c1");
        bus.start = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 2); cyc("p4_start_ignored");
        bus.start = 1'b0;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 3); cyc("p4_c3");
        push_exp(S_RUN, 0, 1, 1, 1, 0, 0, 0); cyc("p4_tick1");
        bus.irq_ack = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 1); cyc("p4_ack");
        bus.irq_ack = 1'b0;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 2); cyc("p4_c2b");
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 3); cyc("p4_c3b");
        push_exp(S_RUN, 0, 1, 1, 1, 0, 0, 0); cyc("p4_tick2");
        push_exp(S_RUN, 0, 1, 0, 1, 0, 0, 1); cyc("p4_c1c");
        bus.stop = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 1, 0, 0, 0); cyc("p4_stop");
        bus.stop = 1'b0; bus.irq_ack = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("irq_clear");
        bus.irq_ack = 1'b0;

        // P=3 one-shot, config and start on the same edge
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd3; bus.cfg_periodic = 1'b0;
        bus.start = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 0); cyc("p3_c0");
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 1); cyc("p3_c1");
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 2); cyc("p3_c2");
        push_exp(S_DONE, 1, 0, 1, 1, 0, 0, 0); cyc("p3_tick_done");
        push_exp(S_DONE, 1, 0, 0, 1, 0, 0, 0); cyc("p3_single_tick");
        push_exp(S_DONE, 1, 0, 0, 1, 0, 0, 0); cyc("p3_stays_done");

        // P=2 periodic, irq left pending -> ovf
        bus.irq_ack = 1'b1;
        push_exp(S_DONE, 1, 0, 0, 0, 0, 0, 0); cyc("p3_ack");
        bus.irq_ack = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd2; bus.cfg_periodic = 1'b1;
        push_exp(S_DONE, 1, 0, 0, 0, 0, 0, 0); cyc("cfg2");
        bus.cfg_valid = 1'b0; bus.start = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 0); cyc("p2_start_from_done");
        bus.start = 1'b0;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 1); cyc("p2_c1");
        push_exp(S_RUN, 0, 1, 1, 1, 0, 0, 0); cyc("p2_tick1");
        push_exp(S_RUN, 0, 1, 0, 1, 0, 0, 1); cyc("p2_c1b");
        push_exp(S_RUN, 0, 1, 1, 1, 1, 0, 0); cyc("p2_ovf");
        bus.stop = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 1, 1, 0, 0); cyc("p2_stop");
        bus.stop = 1'b0;
        push_exp(S_IDLE, 1, 0, 0, 1, 1, 0, 0); cyc("ovf_sticky");
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd5; bus.cfg_periodic = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 1, 0, 0, 0); cyc("cfg_clears_ovf");
        bus.cfg_valid = 1'b0; bus.irq_ack = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("irq_clear2");
        bus.irq_ack = 1'b0;

        // P=5, stop on the expiry cycle
        bus.start = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 0); cyc("p5_c0");
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_exp(S_RUN, 0, 1, 0, 0, 0, 0, DW'(i)); cyc("p5_count");
        end
        bus.stop = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("p5_stop_expiry");
        bus.stop = 1'b0;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("p5_no_tick");

        // P=1 periodic: tick every cycle; ack with a new tick keeps irq
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd1; bus.cfg_periodic = 1'b1;
        bus.start = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 0); cyc("p1_c0");
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        push_exp(S_RUN, 0, 1, 1, 1, 0, 0, 0); cyc("p1_tick1");
        push_exp(S_RUN, 0, 1, 1, 1, 1, 0, 0); cyc("p1_tick2_ovf");
        bus.irq_ack = 1'b1;
        push_exp(S_RUN, 0, 1, 1, 1, 1, 0, 0); cyc("p1_ack_with_tick");
        bus.irq_ack = 1'b0;
        bus.stop = 1'b1; bus.start = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 1, 1, 0, 0); cyc("stop_wins");
        bus.stop = 1'b0; bus.start = 1'b0; bus.irq_ack = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 1, 0, 0); cyc("irq_clear3");
        bus.irq_ack = 1'b0;

        // P=31, reset between edges mid-RUN
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd31; bus.cfg_periodic = 1'b1;
        bus.start = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 0); cyc("p31_c0");
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 1); cyc("p31_c1");
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 2); cyc("p31_c2");
        #3 reset = 1'b1;
        #1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); chk_now("rst_async");
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); cyc("rst_hold");
        #2 reset = 1'b0;
        #1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 0, 0); chk_now("rst_release");
        bus.start = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 0, 0, 1, 0); cyc("rst_cleared_period");
        bus.cfg_valid = 1'b1; bus.cfg_period = 5'd31; bus.cfg_periodic = 1'b1;
        push_exp(S_RUN, 0, 1, 0, 0, 0, 0, 0); cyc("rst_resume");
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            push_exp(S_RUN, 0, 1, 0, 0, 0, 0, DW'(i)); cyc("p31_count");
        end
        push_exp(S_RUN, 0, 1, 1, 1, 0, 0, 0); cyc("p31_max_tick");
        bus.stop = 1'b1;
        push_exp(S_IDLE, 1, 0, 0, 1, 0, 0, 0); cyc("p31_stop");
        bus.stop = 1'b0;

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
